// File: rtl/atm_controller.sv
// Single-card ATM session controller: card, language, PIN check, then a withdraw/deposit/balance/exit menu.
// Latency: every transition and balance commit takes effect on the next rising edge of clk.
// Backpressure: none; a withdrawal larger than the balance holds the FSM in WITHDRAW until the amount fits or the user aborts.
module atm_controller #(
  parameter logic [3:0] CORRECT_PIN  = 4'b1111,
  parameter logic [7:0] INIT_BALANCE = 8'd100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Insert_card,
  input  logic       Language_chosen,
  input  logic [3:0] Pin,
  input  logic [1:0] Operation,
  input  logic [5:0] WithDraw_Amount,
  input  logic [5:0] Deposit_Amount,
  input  logic       home_in,
  input  logic       exit,
  output logic [7:0] Check_balance,
  output logic [7:0] FinalBalance
);

  // Explicit encoding so the session state can be identified when debugging.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LANG     = 3'd1,
    S_PIN      = 3'd2,
    S_MENU     = 3'd3,
    S_WITHDRAW = 3'd4,
    S_DEPOSIT  = 3'd5,
    S_BALANCE  = 3'd6,
    S_EXIT     = 3'd7
  } state_t;

  localparam logic [1:0] OP_WITHDRAW = 2'b00;
  localparam logic [1:0] OP_DEPOSIT  = 2'b01;
  localparam logic [1:0] OP_BALANCE  = 2'b10;

  state_t     r_state;
  logic [7:0] r_balance;
  logic [7:0] r_final_balance;

  // Amounts are 6-bit unsigned and are zero-extended before any arithmetic.
  logic [7:0] w_wd_amt;
  logic       w_wd_ok;
  logic [7:0] w_wd_bal;
  logic [8:0] w_dep_sum;
  logic [7:0] w_dep_bal;
  logic       w_abort;
  logic       w_pin_ok;
  logic       w_in_session;

  assign w_wd_amt     = {2'b00, WithDraw_Amount};
  // Only subtract when the amount fits, so the balance can never underflow.
  assign w_wd_ok      = (w_wd_amt <= r_balance);
  assign w_wd_bal     = r_balance - w_wd_amt;
  // One extra carry bit detects overflow; the sum clamps at 255 instead of wrapping.
  assign w_dep_sum    = {1'b0, r_balance} + {3'b000, Deposit_Amount};
  assign w_dep_bal    = w_dep_sum[8] ? 8'hFF : w_dep_sum[7:0];
  // Pressing exit or pulling the card ends the session from any non-idle state.
  assign w_abort      = exit | ~Insert_card;
  assign w_pin_ok     = (Pin == CORRECT_PIN);
  assign w_in_session = (r_state != S_IDLE);

  assign Check_balance = r_balance;
  assign FinalBalance  = r_final_balance;

  // Session FSM with the balance and the last committed balance as registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_balance       <= INIT_BALANCE;
      r_final_balance <= 8'd0;
    end else if (w_in_session && w_abort) begin
      // Abort leaves both balance registers untouched.
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Insert_card) begin
            r_state <= S_LANG;
          end
        end

        S_LANG: begin
          if (Language_chosen) begin
            r_state <= S_PIN;
          end
        end

        S_PIN: begin
          // Single attempt per card insertion; a wrong PIN ejects back to idle.
          r_state <= w_pin_ok ? S_MENU : S_IDLE;
        end

        S_MENU: begin
          case (Operation)
            OP_WITHDRAW: r_state <= S_WITHDRAW;
            OP_DEPOSIT:  r_state <= S_DEPOSIT;
            OP_BALANCE:  r_state <= S_BALANCE;
            default:     r_state <= S_EXIT;
          endcase
        end

        S_WITHDRAW: begin
          if (home_in) begin
            r_state <= S_MENU;
          end else if (w_wd_ok) begin
            r_balance       <= w_wd_bal;
            r_final_balance <= w_wd_bal;
            r_state         <= S_MENU;
          end
          // Insufficient funds: stay here and re-evaluate the request next cycle.
        end

        S_DEPOSIT: begin
          if (home_in) begin
            r_state <= S_MENU;
          end else begin
            r_balance       <= w_dep_bal;
            r_final_balance <= w_dep_bal;
            r_state         <= S_MENU;
          end
        end

        S_BALANCE: begin
          if (home_in) begin
            r_state <= S_MENU;
          end else begin
            r_final_balance <= r_balance;
            r_state         <= S_MENU;
          end
        end

        S_EXIT: begin
          // A card still present simply starts a new session from IDLE next cycle.
          r_final_balance <= r_balance;
          r_state         <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atm_controller.sv
// Directed bench for atm_controller: drives a linear sequence of sessions and checks
// the balance outputs and the session state after each edge against hand-computed values.
module tb_atm_controller;

  localparam logic [7:0] ST_IDLE     = 8'd0;
  localparam logic [7:0] ST_LANG     = 8'd1;
  localparam logic [7:0] ST_PIN      = 8'd2;
  localparam logic [7:0] ST_MENU     = 8'd3;
  localparam logic [7:0] ST_WITHDRAW = 8'd4;
  localparam logic [7:0] ST_DEPOSIT  = 8'd5;

  logic       clk;
  logic       rst;
  logic       Insert_card;
  logic       Language_chosen;
  logic [3:0] Pin;
  logic [1:0] Operation;
  logic [5:0] WithDraw_Amount;
  logic [5:0] Deposit_Amount;
  logic       home_in;
  logic       exit;
  logic [7:0] Check_balance;
  logic [7:0] FinalBalance;

  int n_pass  = 0;
  int n_total = 0;

  atm_controller dut (
    .clk             (clk),
    .rst             (rst),
    .Insert_card     (Insert_card),
    .Language_chosen (Language_chosen),
    .Pin             (Pin),
    .Operation       (Operation),
    .WithDraw_Amount (WithDraw_Amount),
    .Deposit_Amount  (Deposit_Amount),
    .home_in         (home_in),
    .exit            (exit),
    .Check_balance   (Check_balance),
    .FinalBalance    (FinalBalance)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs and samples both sit 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [7:0] cur_state();
    logic [2:0] s;
    s = dut.r_state;
    return {5'b00000, s};
  endfunction

  task automatic check_all(input string tag, input logic [7:0] st, input logic [7:0] bal, input logic [7:0] fin);
    check({tag, ".state"}, cur_state(), st);
    check({tag, ".bal"},   Check_balance, bal);
    check({tag, ".final"}, FinalBalance, fin);
  endtask

  // Card in, language chosen, correct PIN: IDLE -> LANG -> PIN -> MENU.
  task automatic login();
    Insert_card = 1'b1; Language_chosen = 1'b1; Pin = 4'b1111;
    step(); step(); step();
  endtask

  // Menu selection plus one cycle in the transaction state.
  task automatic txn(input logic [1:0] op, input logic [5:0] wd, input logic [5:0] dep);
    Operation = op; WithDraw_Amount = wd; Deposit_Amount = dep;
    step(); step();
  endtask

  initial begin
    rst = 1'b1; Insert_card = 1'b0; Language_chosen = 1'b0; Pin = 4'b0000;
    Operation = 2'b10; WithDraw_Amount = 6'd0; Deposit_Amount = 6'd0;
    home_in = 1'b0; exit = 1'b0;
    step(); step();
    rst = 1'b0;
    check_all("reset", ST_IDLE, 8'd100, 8'd0);
    step();
    check("idle_no_card", cur_state(), ST_IDLE);

    // Step-by-step login with intermediate states.
    Insert_card = 1'b1;
    step();
    check("lang", cur_state(), ST_LANG);
    step();
    check("lang_wait", cur_state(), ST_LANG);
    Language_chosen = 1'b1;
    step();
    check("pin", cur_state(), ST_PIN);
    Pin = 4'b1111;
    step();
    check("menu", cur_state(), ST_MENU);

    // Balance inquiry.
    txn(2'b10, 6'd0, 6'd0);
    check_all("balance", ST_MENU, 8'd100, 8'd100);

    // Withdraw 30, deposit 20.
    txn(2'b00, 6'd30, 6'd0);
    check_all("wd30", ST_MENU, 8'd70, 8'd70);
    txn(2'b01, 6'd0, 6'd20);
    check_all("dep20", ST_MENU, 8'd90, 8'd90);

    // Bring balance to 20: 90-63=27, 27-7=20.
    txn(2'b00, 6'd63, 6'd0);
    check("wd63.bal", Check_balance, 8'd27);
    txn(2'b00, 6'd7, 6'd0);
    check_all("wd7", ST_MENU, 8'd20, 8'd20);

    // Insufficient funds: stuck in WITHDRAW.
    txn(2'b00, 6'd50, 6'd0);
    check_all("wd50_hold", ST_WITHDRAW, 8'd20, 8'd20);
    step();
    check_all("wd50_hold2", ST_WITHDRAW, 8'd20, 8'd20);
    home_in = 1'b1;
    step();
    home_in = 1'b0;
    check_all("home", ST_MENU, 8'd20, 8'd20);

    // Exact-balance withdrawal, then a zero withdrawal no-op commit.
    txn(2'b00, 6'd20, 6'd0);
    check_all("wd20", ST_MENU, 8'd0, 8'd0);
    txn(2'b00, 6'd0, 6'd0);
    check_all("wd0", ST_MENU, 8'd0, 8'd0);

    // Exit with card still present: IDLE, then a fresh session at LANG.
    Operation = 2'b11;
    step();
    step();
    check_all("exit_op", ST_IDLE, 8'd0, 8'd0);
    step();
    check("reenter_lang", cur_state(), ST_LANG);
    step();
    check("reenter_pin", cur_state(), ST_PIN);
    Pin = 4'b0101;
    step();
    check_all("bad_pin", ST_IDLE, 8'd0, 8'd0);
    Pin = 4'b1111;
    login();
    check("good_pin", cur_state(), ST_MENU);

    // Build balance to 250: 4 x 63 = 252, minus 2.
    for (int i = 0; i < 4; i++) txn(2'b01, 6'd0, 6'd63);
    check("dep252.bal", Check_balance, 8'd252);
    txn(2'b00, 6'd2, 6'd0);
    check("wd2.bal", Check_balance, 8'd250);
    txn(2'b01, 6'd0, 6'd31);
    check_all("dep_sat", ST_MENU, 8'd255, 8'd255);
    txn(2'b01, 6'd0, 6'd10);
    check_all("dep_sat2", ST_MENU, 8'd255, 8'd255);

    // Withdraw 55 -> 200 so the abort checks see a distinct value.
    txn(2'b00, 6'd55, 6'd0);
    check_all("wd55", ST_MENU, 8'd200, 8'd200);

    // exit pressed while in DEPOSIT: no commit.
    Operation = 2'b01; Deposit_Amount = 6'd5;
    step();
    check("in_deposit", cur_state(), ST_DEPOSIT);
    exit = 1'b1;
    step();
    exit = 1'b0;
    check_all("exit_abort", ST_IDLE, 8'd200, 8'd200);

    // Card pulled while in MENU.
    Insert_card = 1'b0;
    step();
    login();
    check("menu_again", cur_state(), ST_MENU);
    Insert_card = 1'b0;
    step();
    check_all("card_pulled", ST_IDLE, 8'd200, 8'd200);

    // Reset mid-session reloads the initial balance.
    login();
    check("menu_pre_rst", cur_state(), ST_MENU);
    rst = 1'b1;
    step();
    rst = 1'b0;
    Insert_card = 1'b0;
    check_all("rst_mid", ST_IDLE, 8'd100, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Guard against an unexpected stall of the stimulus sequence.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
